// File: rtl/tt_um_emern_frame_sched.sv
// Frame-synchronous commit scheduler: stages polygon-slot writes and releases them to the bank only during blanking.
// Optional macro FRAME_SCHED_COALESCE_EN: a write to a slot already pending overwrites that entry in place.
//   state      | meaning
//   WAIT_BLANK | idle, waiting for a blanking rising edge with pending entries
//   DRAIN      | popping the snapshotted entries, one per blank cycle
//   DONE       | drain finished with at least one commit; frame_done follows
module tt_um_emern_frame_sched #(
    parameter int N_POLY = 4,
    parameter int SLOT_W = $clog2(N_POLY),
    parameter int WREC   = 46,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [SLOT_W-1:0]       wr_slot,
    input  logic [WREC-1:0]         wr_data,
    input  logic                    screen_inactive,
    output logic                    commit_valid,
    output logic [SLOT_W-1:0]       commit_slot,
    output logic [WREC-1:0]         commit_data,
    output logic                    frame_done,
    output logic                    irq,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {WAIT_BLANK, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic              blank_q;
    logic [CW-1:0]     snap;
    logic [CW-1:0]     count;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [SLOT_W-1:0] mem_slot [DEPTH];
    logic [WREC-1:0]   mem_data [DEPTH];

    logic blank_rise, full, pop, push_new, coal;

    assign blank_rise = screen_inactive & ~blank_q;
    assign full       = (count == CW'(DEPTH));
    assign pop        = (state == DRAIN) && screen_inactive && (snap != '0);
    assign irq        = !full && (state != DRAIN);
    assign fifo_count = count;

`ifdef FRAME_SCHED_COALESCE_EN
    logic          hit;
    logic [PW-1:0] hit_idx;

    // Later matches overwrite earlier ones so the newest pending entry wins; a head being popped is excluded.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                if ((mem_slot[rd_ptr + PW'(k)] == wr_slot) && !(pop && (k == 0))) begin
                    hit     = 1'b1;
                    hit_idx = rd_ptr + PW'(k);
                end
            end
        end
    end

    assign coal     = wr_valid && hit;
    assign wr_ready = !full || coal;
    assign push_new = wr_valid && !full && !hit;
`else
    assign coal     = 1'b0;
    assign wr_ready = !full;
    assign push_new = wr_valid && !full;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_new) begin
                mem_slot[wr_ptr] <= wr_slot;
                mem_data[wr_ptr] <= wr_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
`ifdef FRAME_SCHED_COALESCE_EN
            if (coal)
                mem_data[hit_idx] <= wr_data;
`endif
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_new, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_BLANK: if (blank_rise && (count != '0)) state_nxt = DRAIN;
            DRAIN: begin
                if (!screen_inactive)       state_nxt = WAIT_BLANK;
                else if (snap == CW'(1))    state_nxt = DONE;
                else if (snap == '0)        state_nxt = WAIT_BLANK;
            end
            DONE:       state_nxt = WAIT_BLANK;
            default:    state_nxt = WAIT_BLANK;
        endcase
    end

    // blank_q resets high so a reset taken inside blanking cannot fake a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_BLANK;
            blank_q      <= 1'b1;
            snap         <= '0;
            commit_valid <= 1'b0;
            commit_slot  <= '0;
            commit_data  <= '0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            blank_q      <= screen_inactive;
            commit_valid <= pop;
            frame_done   <= (state == DONE);
            if ((state == WAIT_BLANK) && blank_rise)
                snap <= count;
            else if (pop)
                snap <= snap - CW'(1);
            if (pop) begin
                commit_slot <= mem_slot[rd_ptr];
                commit_data <= mem_data[rd_ptr];
            end
        end
    end

    // coal is consumed only in the coalescing build; keep it referenced in the default build too.
    logic unused_ok;
    assign unused_ok = coal;
endmodule

// File: tb/tb_tt_um_emern_frame_sched.sv
// Directed bench for tt_um_emern_frame_sched: vector table plus a bounded back-to-back drain sequence.
module tb_tt_um_emern_frame_sched;
    localparam int SLOT_W = 2;
    localparam int WREC   = 46;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [SLOT_W-1:0] wr_slot = '0;
    logic [WREC-1:0]   wr_data = '0;
    logic              screen_inactive = 1'b0;
    logic              commit_valid;
    logic [SLOT_W-1:0] commit_slot;
    logic [WREC-1:0]   commit_data;
    logic              frame_done;
    logic              irq;
    logic [2:0]        fifo_count;

    always #5 clk = ~clk;

    tt_um_emern_frame_sched #(.N_POLY(4), .SLOT_W(SLOT_W), .WREC(WREC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_slot(wr_slot), .wr_data(wr_data), .screen_inactive(screen_inactive),
        .commit_valid(commit_valid), .commit_slot(commit_slot), .commit_data(commit_data),
        .frame_done(frame_done), .irq(irq), .fifo_count(fifo_count)
    );

    typedef struct {
        logic              rst;
        logic              v;
        logic [SLOT_W-1:0] slot;
        logic [WREC-1:0]   data;
        logic              si;
        logic              rdy;
        logic              cv;
        logic [SLOT_W-1:0] cs;
        logic [WREC-1:0]   cd;
        logic              fd;
        logic              irq;
        logic [2:0]        cnt;
    } vec_t;

    vec_t              tbl[$];
    logic [SLOT_W-1:0] hold_cs = '0;
    logic [WREC-1:0]   hold_cd = '0;
    int                checks = 0;
    int                failures = 0;

    function automatic logic [WREC-1:0] rec(input int n);
        return {6'(n), 40'hC0_FFEE_0000 + 40'(n)};
    endfunction

    // Expected commit_slot/commit_data hold their last committed value, and clear on reset.
    task automatic add(input logic r, input logic v, input int s, input int dn, input logic si,
                       input logic rdy, input logic cv, input int cs, input int cdn,
                       input logic fd, input logic ir, input int cnt);
        vec_t e;
        if (r) begin
            hold_cs = '0;
            hold_cd = '0;
        end else if (cv) begin
            hold_cs = 2'(cs);
            hold_cd = rec(cdn);
        end
        e.rst = r;  e.v = v;  e.slot = 2'(s);  e.data = v ? rec(dn) : '0;  e.si = si;
        e.rdy = rdy; e.cv = cv; e.cs = hold_cs; e.cd = hold_cd; e.fd = fd; e.irq = ir;
        e.cnt = 3'(cnt);
        tbl.push_back(e);
    endtask

    task automatic rs(input logic si);
        add(1'b1, 1'b0, 0, 0, si, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 0);
    endtask
    task automatic pu(input int s, input int n, input logic si, input int cnt, input logic rdy, input logic ir);
        add(1'b0, 1'b1, s, n, si, rdy, 1'b0, 0, 0, 1'b0, ir, cnt);
    endtask
    task automatic id(input logic si, input int cnt, input logic rdy, input logic ir, input logic fd);
        add(1'b0, 1'b0, 0, 0, si, rdy, 1'b0, 0, 0, fd, ir, cnt);
    endtask
    task automatic cm(input logic si, input int cs, input int n, input int cnt, input logic rdy, input logic ir);
        add(1'b0, 1'b0, 0, 0, si, rdy, 1'b1, cs, n, 1'b0, ir, cnt);
    endtask

    initial begin
        int n_commit, first_c, last_c, fd_c;

        // basic drain of three entries in slot order
        rs(1'b0);
        pu(0, 1, 1'b0, 1, 1'b1, 1'b1);  pu(1, 2, 1'b0, 2, 1'b1, 1'b1);  pu(2, 3, 1'b0, 3, 1'b1, 1'b1);
        id(1'b1, 3, 1'b1, 1'b0, 1'b0);
        cm(1'b1, 0, 1, 2, 1'b1, 1'b0);  cm(1'b1, 1, 2, 1, 1'b1, 1'b0);  cm(1'b1, 2, 3, 0, 1'b1, 1'b1);
        id(1'b1, 0, 1'b1, 1'b1, 1'b1);  id(1'b1, 0, 1'b1, 1'b1, 1'b0);  id(1'b0, 0, 1'b1, 1'b1, 1'b0);
`ifndef FRAME_SCHED_COALESCE_EN
        // full FIFO: refusal, no bypass on the first pop, acceptance after it
        pu(0, 10, 1'b0, 1, 1'b1, 1'b1); pu(1, 11, 1'b0, 2, 1'b1, 1'b1);
        pu(2, 12, 1'b0, 3, 1'b1, 1'b1); pu(3, 13, 1'b0, 4, 1'b0, 1'b0);
        pu(0, 14, 1'b0, 4, 1'b0, 1'b0);
        pu(0, 14, 1'b1, 4, 1'b0, 1'b0);
        add(1'b0, 1'b1, 0, 14, 1'b1, 1'b1, 1'b1, 0, 10, 1'b0, 1'b0, 3);
        add(1'b0, 1'b1, 0, 14, 1'b1, 1'b1, 1'b1, 1, 11, 1'b0, 1'b0, 3);
        cm(1'b1, 2, 12, 2, 1'b1, 1'b0); cm(1'b1, 3, 13, 1, 1'b1, 1'b1);
        id(1'b1, 1, 1'b1, 1'b1, 1'b1);  id(1'b0, 1, 1'b1, 1'b1, 1'b0);
        id(1'b1, 1, 1'b1, 1'b0, 1'b0);  cm(1'b1, 0, 14, 0, 1'b1, 1'b1);
        id(1'b1, 0, 1'b1, 1'b1, 1'b1);  id(1'b0, 0, 1'b1, 1'b1, 1'b0);
`endif
        // blank ends after two commits; remainder drains next blank
        pu(0, 20, 1'b0, 1, 1'b1, 1'b1); pu(1, 21, 1'b0, 2, 1'b1, 1'b1);
        pu(2, 22, 1'b0, 3, 1'b1, 1'b1); pu(3, 23, 1'b0, 4, 1'b0, 1'b0);
        id(1'b1, 4, 1'b0, 1'b0, 1'b0);
        cm(1'b1, 0, 20, 3, 1'b1, 1'b0); cm(1'b1, 1, 21, 2, 1'b1, 1'b0);
        id(1'b0, 2, 1'b1, 1'b1, 1'b0);  id(1'b0, 2, 1'b1, 1'b1, 1'b0);
        id(1'b1, 2, 1'b1, 1'b0, 1'b0);
        cm(1'b1, 2, 22, 1, 1'b1, 1'b0); cm(1'b1, 3, 23, 0, 1'b1, 1'b1);
        id(1'b1, 0, 1'b1, 1'b1, 1'b1);  id(1'b0, 0, 1'b1, 1'b1, 1'b0);
        // snapshot: pushes during the blank wait for the next one
        pu(1, 30, 1'b0, 1, 1'b1, 1'b1);
        pu(2, 31, 1'b1, 2, 1'b1, 1'b0);
        add(1'b0, 1'b1, 3, 32, 1'b1, 1'b1, 1'b1, 1, 30, 1'b0, 1'b1, 2);
        id(1'b1, 2, 1'b1, 1'b1, 1'b1);  id(1'b0, 2, 1'b1, 1'b1, 1'b0);
        id(1'b1, 2, 1'b1, 1'b0, 1'b0);
        cm(1'b1, 2, 31, 1, 1'b1, 1'b0); cm(1'b1, 3, 32, 0, 1'b1, 1'b1);
        id(1'b1, 0, 1'b1, 1'b1, 1'b1);  id(1'b0, 0, 1'b1, 1'b1, 1'b0);
`ifdef FRAME_SCHED_COALESCE_EN
        pu(1, 50, 1'b0, 1, 1'b1, 1'b1); pu(2, 51, 1'b0, 2, 1'b1, 1'b1); pu(1, 52, 1'b0, 2, 1'b1, 1'b1);
        id(1'b1, 2, 1'b1, 1'b0, 1'b0);
        cm(1'b1, 1, 52, 1, 1'b1, 1'b0); cm(1'b1, 2, 51, 0, 1'b1, 1'b1);
        id(1'b1, 0, 1'b1, 1'b1, 1'b1);  id(1'b0, 0, 1'b1, 1'b1, 1'b0);
`else
        pu(1, 40, 1'b0, 1, 1'b1, 1'b1); pu(1, 41, 1'b0, 2, 1'b1, 1'b1);
        id(1'b1, 2, 1'b1, 1'b0, 1'b0);
        cm(1'b1, 1, 40, 1, 1'b1, 1'b0); cm(1'b1, 1, 41, 0, 1'b1, 1'b1);
        id(1'b1, 0, 1'b1, 1'b1, 1'b1);  id(1'b0, 0, 1'b1, 1'b1, 1'b0);
`endif
        // reset right after entering DRAIN with three pending; rest of blank stays quiet
        pu(0, 60, 1'b0, 1, 1'b1, 1'b1); pu(1, 61, 1'b0, 2, 1'b1, 1'b1); pu(2, 62, 1'b0, 3, 1'b1, 1'b1);
        id(1'b1, 3, 1'b1, 1'b0, 1'b0);
        rs(1'b1);
        id(1'b1, 0, 1'b1, 1'b1, 1'b0);  id(1'b1, 0, 1'b1, 1'b1, 1'b0);
        id(1'b1, 0, 1'b1, 1'b1, 1'b0);  id(1'b0, 0, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst;  wr_valid = tbl[i].v;  wr_slot = tbl[i].slot;
            wr_data = tbl[i].data;  screen_inactive = tbl[i].si;
            @(posedge clk);
            #1 wr_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({wr_ready, commit_valid, commit_slot, commit_data, frame_done, irq, fifo_count} !==
                {tbl[i].rdy, tbl[i].cv, tbl[i].cs, tbl[i].cd, tbl[i].fd, tbl[i].irq, tbl[i].cnt}) begin
                failures++;
                $display("FAIL vec%0d got rdy=%b cv=%b cs=%0d cd=%h fd=%b irq=%b cnt=%0d want rdy=%b cv=%b cs=%0d cd=%h fd=%b irq=%b cnt=%0d",
                         i, wr_ready, commit_valid, commit_slot, commit_data, frame_done, irq, fifo_count,
                         tbl[i].rdy, tbl[i].cv, tbl[i].cs, tbl[i].cd, tbl[i].fd, tbl[i].irq, tbl[i].cnt);
            end
        end

        // back-to-back drain of a full FIFO with a bounded wait for frame_done
        rst = 1'b0;
        screen_inactive = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_valid = 1'b1;  wr_slot = 2'(k);  wr_data = rec(100 + k);
            @(posedge clk);
            #1 wr_valid = 1'b0;
            @(negedge clk);
        end
        screen_inactive = 1'b1;
        n_commit = 0;  first_c = -1;  last_c = -1;  fd_c = -1;
        for (int c = 0; c < 20 && fd_c < 0; c++) begin
            @(negedge clk);
            if (commit_valid) begin
                checks++;
                if (commit_slot !== 2'(n_commit) || commit_data !== rec(100 + n_commit)) begin
                    failures++;
                    $display("FAIL burst_commit%0d got slot=%0d data=%h want slot=%0d data=%h",
                             n_commit, commit_slot, commit_data, n_commit, rec(100 + n_commit));
                end
                if (n_commit == 0) first_c = c;
                last_c = c;
                n_commit++;
            end
            if (frame_done) fd_c = c;
        end
        checks++;
        if (n_commit != DEPTH) begin
            failures++;
            $display("FAIL burst_count got %0d want %0d", n_commit, DEPTH);
        end
        checks++;
        if (last_c - first_c != DEPTH - 1) begin
            failures++;
            $display("FAIL burst_bubbles got span %0d want %0d", last_c - first_c, DEPTH - 1);
        end
        checks++;
        if (fd_c < 0 || fd_c != last_c + 1) begin
            failures++;
            $display("FAIL burst_frame_done got cycle %0d want %0d (-1 = timeout)", fd_c, last_c + 1);
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL burst_empty got %0d want 0", fifo_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
